// File: rtl/mms_frame_tracker_pkg.sv
// Shared definitions for the max/min frame tracker: select encoding, FSM states
// and the padding value used for partially filled lane groups.
package mms_pkg;

    localparam logic MMS_SEL_MAX = 1'b0;
    localparam logic MMS_SEL_MIN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } mms_state_t;

    // Value that can never win the compare: 0 when looking for a max, all-ones for a min.
    function automatic logic [31:0] neutral(input logic sel, input int w);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF >> (32 - w);
        return (sel == MMS_SEL_MIN) ? ones : 32'd0;
    endfunction

endpackage

// File: rtl/mms_frame_tracker_if.sv
// Sample-in / result-out bundle of the frame tracker; slave is the tracker side.
interface mms_frame_tracker_if #(
    parameter int W     = 8,
    parameter int CNT_W = 16
);
    logic             select;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_result;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    modport slave (
        input  select, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_result, out_count, busy
    );

    modport master (
        output select, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_count, busy
    );
endinterface

// File: rtl/mms_frame_tracker_cmp4.sv
// Combinational 4-input unsigned max/min: two pairwise compares, then a final one.
import mms_pkg::*;

module mms_cmp4 #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] y
);
    logic [W-1:0] ab;
    logic [W-1:0] cd;

    always_comb begin
        if (sel == MMS_SEL_MIN) begin
            ab = (a < b) ? a : b;
            cd = (c < d) ? c : d;
            y  = (ab < cd) ? ab : cd;
        end else begin
            ab = (a > b) ? a : b;
            cd = (c > d) ? c : d;
            y  = (ab > cd) ? ab : cd;
        end
    end
endmodule

// File: rtl/mms_frame_tracker.sv
// Streaming frame tracker: packs samples into 4-lane groups, reduces each group and
// folds it into a running max/min, then hands {result, count} downstream.
import mms_pkg::*;

module mms_frame_tracker #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    mms_frame_tracker_if.slave  bus
);
    mms_state_t       state;
    logic             sel_q;
    logic [1:0]       lane_idx;
    logic [W-1:0]     lane_q [3];
    logic [W-1:0]     acc_q;
    logic             first_grp_q;
    logic [CNT_W-1:0] count_q;
    logic [W-1:0]     result_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_valid_q;

    logic             accept;
    logic             fold;
    logic             sel_eff;
    logic [W-1:0]     neut;
    logic [W-1:0]     g0, g1, g2, g3;
    logic [W-1:0]     grp;
    logic [W-1:0]     acc_next;
    logic [CNT_W-1:0] count_next;

    assign bus.in_ready   = (state != ST_DONE);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_count  = out_count_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign fold    = accept & ((lane_idx == 2'd3) | bus.in_last);
    // The first sample of a frame uses the live select; later samples use the latched one.
    assign sel_eff = (state == ST_IDLE) ? bus.select : sel_q;
    assign neut    = W'(neutral(sel_eff, W));

    always_comb begin
        g0 = (lane_idx == 2'd0) ? bus.in_data : lane_q[0];
        g1 = (lane_idx == 2'd1) ? bus.in_data : ((lane_idx > 2'd1) ? lane_q[1] : neut);
        g2 = (lane_idx == 2'd2) ? bus.in_data : ((lane_idx == 2'd3) ? lane_q[2] : neut);
        g3 = (lane_idx == 2'd3) ? bus.in_data : neut;
    end

    mms_cmp4 #(.W(W)) u_cmp4 (
        .sel (sel_eff),
        .a   (g0),
        .b   (g1),
        .c   (g2),
        .d   (g3),
        .y   (grp)
    );

    always_comb begin
        if (first_grp_q)
            acc_next = grp;
        else if (sel_eff == MMS_SEL_MIN)
            acc_next = (acc_q < grp) ? acc_q : grp;
        else
            acc_next = (acc_q > grp) ? acc_q : grp;

        if (state == ST_IDLE)
            count_next = CNT_W'(1);
        else if (&count_q)
            count_next = count_q;
        else
            count_next = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            sel_q       <= MMS_SEL_MAX;
            lane_idx    <= 2'd0;
            lane_q[0]   <= '0;
            lane_q[1]   <= '0;
            lane_q[2]   <= '0;
            acc_q       <= '0;
            first_grp_q <= 1'b1;
            count_q     <= '0;
            result_q    <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                count_q <= count_next;
                if (state == ST_IDLE)
                    sel_q <= bus.select;
                if (fold) begin
                    lane_idx    <= 2'd0;
                    acc_q       <= acc_next;
                    first_grp_q <= 1'b0;
                end else begin
                    lane_idx <= lane_idx + 2'd1;
                    case (lane_idx)
                        2'd0:    lane_q[0] <= bus.in_data;
                        2'd1:    lane_q[1] <= bus.in_data;
                        default: lane_q[2] <= bus.in_data;
                    endcase
                end
            end

            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (accept && bus.in_last) begin
                        state       <= ST_DONE;
                        result_q    <= acc_next;
                        out_count_q <= count_next;
                        out_valid_q <= 1'b1;
                        first_grp_q <= 1'b1;
                    end else if (accept) begin
                        state <= ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
